// File: rtl/mdc8p_ctrl_out.sv
// Output controller for the 8-point MDC FFT: gathers two-lane frames into a
// ping-pong register buffer and streams them serially on an AXI4-Stream master.
module mdc8p_ctrl_out #(
  parameter int NB          = 8,
  parameter bit BIT_REVERSE = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic signed [NB-1:0] i_data0_r,
  input  logic signed [NB-1:0] i_data0_i,
  input  logic signed [NB-1:0] i_data1_r,
  input  logic signed [NB-1:0] i_data1_i,
  input  logic                 i_valid,
  output logic                 m_axis_data_tvalid,
  output logic [2*NB-1:0]      m_axis_data_tdata,
  output logic                 m_axis_data_tlast,
  input  logic                 m_axis_data_tready,
  output logic                 o_overflow
);

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  function automatic logic [2:0] rd_addr(input logic [2:0] n);
    return BIT_REVERSE ? bitrev3(n) : n;
  endfunction

  logic signed [NB-1:0] bank_r [2][8];
  logic signed [NB-1:0] bank_i [2][8];

  logic [1:0] full_p1;
  logic       wr_bank_p1;
  logic [1:0] wr_cnt_p1;
  logic       drop_p1;
  logic       overflow_p1;
  logic       rd_bank_p1;
  logic [2:0] rd_cnt_p1;

  logic       first_beat;
  logic       drop_now;
  logic       wr_en;
  logic       frame_done;
  logic       rd_hs;
  logic       rd_done;
  logic [1:0] full_next;

  // The drop decision is latched at the first beat so the rest of the frame follows it.
  always_comb begin
    first_beat = i_valid && (wr_cnt_p1 == 2'd0);
    drop_now   = first_beat ? full_p1[wr_bank_p1] : drop_p1;
    wr_en      = i_valid && !drop_now;
    frame_done = wr_en && (wr_cnt_p1 == 2'd3);
    rd_hs      = full_p1[rd_bank_p1] && m_axis_data_tready;
    rd_done    = rd_hs && (rd_cnt_p1 == 3'd7);
    full_next  = full_p1;
    if (rd_done)    full_next[rd_bank_p1] = 1'b0;
    if (frame_done) full_next[wr_bank_p1] = 1'b1;
  end

  // Stage p1: control state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      full_p1     <= 2'b00;
      wr_bank_p1  <= 1'b0;
      wr_cnt_p1   <= 2'd0;
      drop_p1     <= 1'b0;
      overflow_p1 <= 1'b0;
      rd_bank_p1  <= 1'b0;
      rd_cnt_p1   <= 3'd0;
    end else begin
      if (i_valid)    wr_cnt_p1 <= wr_cnt_p1 + 2'd1;
      if (first_beat) drop_p1 <= full_p1[wr_bank_p1];
      if (frame_done) wr_bank_p1 <= ~wr_bank_p1;
      overflow_p1 <= first_beat && full_p1[wr_bank_p1];
      if (rd_hs)      rd_cnt_p1 <= rd_cnt_p1 + 3'd1;
      if (rd_done)    rd_bank_p1 <= ~rd_bank_p1;
      full_p1 <= full_next;
    end
  end

  // Stage p1: buffer storage, lane 0 fills the low half and lane 1 the high half
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      bank_r[wr_bank_p1][{1'b0, wr_cnt_p1}] <= i_data0_r;
      bank_i[wr_bank_p1][{1'b0, wr_cnt_p1}] <= i_data0_i;
      bank_r[wr_bank_p1][{1'b1, wr_cnt_p1}] <= i_data1_r;
      bank_i[wr_bank_p1][{1'b1, wr_cnt_p1}] <= i_data1_i;
    end
  end

  // Data is masked while idle so the bus reads zero out of reset without clearing the banks.
  always_comb begin
    m_axis_data_tvalid = full_p1[rd_bank_p1];
    m_axis_data_tlast  = m_axis_data_tvalid && (rd_cnt_p1 == 3'd7);
    m_axis_data_tdata  = '0;
    if (m_axis_data_tvalid)
      m_axis_data_tdata = {bank_r[rd_bank_p1][rd_addr(rd_cnt_p1)],
                           bank_i[rd_bank_p1][rd_addr(rd_cnt_p1)]};
  end

  assign o_overflow = overflow_p1;

endmodule

// File: doc/mdc8p_ctrl_out.md
# mdc8p_ctrl_out

Output-side controller of the 8-point MDC FFT. It collects each frame from the pipeline's two parallel complex lanes (four beats per frame), stores it in a ping-pong register buffer, and streams the eight samples out serially on an AXI4-Stream master, one sample per handshake, with `tlast` on the eighth. An optional 3-bit bit-reversal on the read address restores natural frequency order. The FFT pipeline cannot be stalled, so the input side has no back-pressure; a frame that finds no free bank is dropped and flagged.

## Interface
- `NB`, 8, bits per real/imaginary component
- `BIT_REVERSE`, 1, 1: output sample n reads buffer address bitrev3(n); 0: reads address n
- `i_clk`  in  1  clock; all logic on the rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_data0_r`, `i_data0_i`  in  NB each  lane 0 complex sample
- `i_data1_r`, `i_data1_i`  in  NB each  lane 1 complex sample
- `i_valid`  in  1  lane data valid, one beat
- `m_axis_data_tvalid`  out  1  AXIS master valid
- `m_axis_data_tdata`  out  2*NB  {real, imag}, real in MSBs
- `m_axis_data_tlast`  out  1  high on the eighth sample of a frame
- `m_axis_data_tready`  in  1  AXIS downstream ready
- `o_overflow`  out  1  one-cycle pulse when an incoming frame is dropped

## Operation
- **Storage.** Two banks, each 8 × {NB real, NB imag}, held in flops. Contents are not reset. Per-bank `full` flag.
- **Write side.**
  - `wr_bank` (1 bit) and `wr_cnt` (2 bits) advance only on beats where `i_valid`=1.
  - Idle cycles mid-frame hold the count.
  - Beat k (k = `wr_cnt`) writes lane 0 to address k and lane 1 to address k+4 of `wr_bank`.
- **Drop rule.**
  - At a frame's first beat (`wr_cnt`==0 and `i_valid`), if `full[wr_bank]`=1, the whole frame is dropped.
  - `o_overflow` pulses on the cycle after that first beat.
  - `wr_cnt` still counts the frame's four beats, but nothing is written and no flag is set.
  - `wr_bank` does not toggle after a dropped frame.
- **Frame completion.** On a kept frame's fourth beat: set `full[wr_bank]`, toggle `wr_bank`, and `wr_cnt` wraps to 0.
- **Read side.** Registers `rd_bank` and `rd_cnt` (3 bits).
  - `tvalid` = `full[rd_bank]`.
  - `tdata` = bank[`rd_bank`][addr(`rd_cnt`)].
  - `tlast` = `tvalid` and `rd_cnt`==7.
- **Read handshake** (`tvalid` and `tready`): increment `rd_cnt`. At `rd_cnt`==7, clear `full[rd_bank]`, toggle `rd_bank`, and `rd_cnt` wraps to 0.
- **AXIS rules.**
  - `tvalid` and `tdata` are driven from registers only; there is no combinational path from `tready`.
  - Once `tvalid` is asserted, `tdata` and `tlast` stay stable until the handshake.
  - A frame is never truncated or reordered across banks.
- **Simultaneous events.**
  - A set on `wr_bank` and a clear on `rd_bank` in the same cycle are legal; they are necessarily different banks.
  - If a clear frees the bank that a first beat targets in that same cycle, the frame is still dropped, because the check uses the pre-edge `full` value.
- **Reset (async).**
  - Outputs: `m_axis_data_tvalid`=0, `m_axis_data_tlast`=0, `m_axis_data_tdata`=0, `o_overflow`=0.
  - State: both `full`=0, `wr_bank`=`rd_bank`=0, `wr_cnt`=`rd_cnt`=0.
  - A reset mid-frame discards all buffered and partial data. Streaming restarts with the first frame after reset.

## Timing
- **Latency.** The fourth input beat is sampled at edge T. `tvalid` is high in the cycle after edge T, presenting sample 0.
- **Throughput.**
  - With `tready` held at 1, one sample per cycle; a frame drains in 8 cycles.
  - Sustained rate is one input frame per 8 cycles.
  - Faster bursts are absorbed by one spare bank, then dropped.
- **Back-to-back frames.** If the next bank is full when the current frame's last handshake occurs, `tvalid` stays high without a gap. Sample 0 of the next frame is presented the following cycle.
- **Overflow flag.** `o_overflow` is high for exactly one cycle per dropped frame.

## Test plan
- **Natural order.** `BIT_REVERSE`=0. One frame with beats k=0..3: lane 0 real=k+1, lane 1 real=k+5, imag = real+16. `tready`=1. Expect real = 1,2,…,8 and imag = 17,…,24 on consecutive cycles, starting the cycle after the 4th beat. `tlast` only on 8.
- **Bit-reversed order.** `BIT_REVERSE`=1, same frame. Expect real order 1,5,3,7,2,6,4,8.
- **Back-pressure.** `tready` toggles 1,0,0,1,… Expect `tdata` to hold during stalls and exactly 8 handshakes, with no duplicates or skips.
- **Ping-pong and drop.** `tready`=0 while three frames are sent. Expect frames 1 and 2 kept, frame 3 dropped, and `o_overflow` pulsing once, one cycle after frame 3's first beat. Then raise `tready`: expect 16 samples (frame 1 then frame 2), `tlast` at 8 and 16, and `tvalid` continuous.
- **Gapped input.** Insert idle cycles between the 4 beats. Expect output identical to the natural-order case.
- **Reset.** Assert `i_rst` mid-stream, after 3 output handshakes. Expect `tvalid`=0 immediately (async). A fresh frame after release streams from sample 0 with correct data.
